// File: rtl/shim_trigger_log_reader_pkg.sv
// Shared shim encodings: trigger command/state plus the log-reader FSM states and
// the timestamp delta helpers.
package shim_trigger_log_reader_pkg;

  typedef enum logic [1:0] {
    TRIG_CMD_NOP   = 2'd0,
    TRIG_CMD_ARM   = 2'd1,
    TRIG_CMD_FIRE  = 2'd2,
    TRIG_CMD_ABORT = 2'd3
  } trig_cmd_e;

  typedef enum logic [1:0] {
    TRIG_ST_OFF   = 2'd0,
    TRIG_ST_ARMED = 2'd1,
    TRIG_ST_FIRED = 2'd2
  } trig_state_e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_LO   = 3'd1,
    S_WAIT_HI = 3'd2,
    S_RD_HI   = 3'd3,
    S_OUT     = 3'd4
  } rdr_state_e;

  localparam logic [31:0] DELTA_SAT = 32'hFFFF_FFFF;

  // Any difference that does not fit in 32 bits pins at DELTA_SAT.
  function automatic logic [31:0] sat_delta(input logic [63:0] cur, input logic [63:0] prev);
    logic [63:0] diff;
    diff = cur - prev;
    return (diff[63:32] != 32'd0) ? DELTA_SAT : diff[31:0];
  endfunction

endpackage

// File: rtl/shim_trigger_log_reader.sv
// Pulls {low, high} word pairs from the trigger-log FIFO and presents them as
// 64-bit timestamps with delta, sequence index and sticky error flags.
//
//   state     | meaning
//   S_IDLE    | waiting for a low word; reads as soon as the FIFO is non-empty
//   S_RD_LO   | low word on data_word; may issue the high-word read immediately
//   S_WAIT_HI | low word held; waiting (bounded) for the high word to arrive
//   S_RD_HI   | high word on data_word; timestamp, delta and order check computed
//   S_OUT     | record presented on ts_*; held until accepted
module shim_trigger_log_reader
  import shim_trigger_log_reader_pkg::*;
#(
  parameter int PAIR_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        data_word_rd_en,
  input  logic [31:0] data_word,
  input  logic        data_buf_empty,
  input  logic        clear,
  output logic        ts_valid,
  input  logic        ts_ready,
  output logic [63:0] ts_time,
  output logic [31:0] ts_delta,
  output logic [15:0] ts_index,
  output logic        partial_err,
  output logic        order_err
);

  localparam int CW = $clog2(PAIR_TIMEOUT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(PAIR_TIMEOUT - 1);

  rdr_state_e    state, next_state;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   lo_word;
  logic [63:0]   prev_time;
  logic          first_rec;
  logic          wait_timeout;
  logic [63:0]   new_time;

  assign new_time = {data_word, lo_word};
  assign ts_valid = (state == S_OUT);

  always_comb begin
    data_word_rd_en = 1'b0;
    wait_timeout    = 1'b0;
    next_state      = state;
    // resetn gates the strobe so the FIFO is never popped while held in reset
    if ((state == S_IDLE || state == S_RD_LO || state == S_WAIT_HI) &&
        !data_buf_empty && !clear && resetn)
      data_word_rd_en = 1'b1;
    case (state)
      S_IDLE:    if (data_word_rd_en) next_state = S_RD_LO;
      S_RD_LO:   next_state = data_word_rd_en ? S_RD_HI : S_WAIT_HI;
      S_WAIT_HI: begin
        if (data_word_rd_en) begin
          next_state = S_RD_HI;
        end else if (data_buf_empty && wait_cnt == WAIT_LAST) begin
          wait_timeout = 1'b1;
          next_state   = S_IDLE;
        end
      end
      S_RD_HI:   next_state = S_OUT;
      S_OUT:     if (ts_ready) next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
    if (clear) next_state = S_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wait_cnt    <= '0;
      lo_word     <= '0;
      prev_time   <= '0;
      first_rec   <= 1'b1;
      ts_time     <= '0;
      ts_delta    <= '0;
      ts_index    <= '0;
      partial_err <= 1'b0;
      order_err   <= 1'b0;
    end else if (clear) begin
      wait_cnt    <= '0;
      first_rec   <= 1'b1;
      ts_index    <= '0;
      partial_err <= 1'b0;
      order_err   <= 1'b0;
    end else begin
      case (state)
        S_RD_LO: begin
          lo_word  <= data_word;
          wait_cnt <= '0;
        end
        S_WAIT_HI: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_timeout) partial_err <= 1'b1;
        end
        S_RD_HI: begin
          ts_time   <= new_time;
          prev_time <= new_time;
          first_rec <= 1'b0;
          if (first_rec) begin
            ts_delta <= '0;
          end else if (new_time <= prev_time) begin
            ts_delta  <= '0;
            order_err <= 1'b1;
          end else begin
            ts_delta <= sat_delta(new_time, prev_time);
          end
        end
        S_OUT: if (ts_ready) ts_index <= ts_index + 16'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shim_trigger_log_reader.sv
// Directed bench for shim_trigger_log_reader with a behavioural non-FWFT FIFO.
module tb_shim_trigger_log_reader;

  logic        clk = 1'b0;
  logic        resetn;
  logic        data_word_rd_en;
  logic [31:0] data_word;
  logic        data_buf_empty;
  logic        clear;
  logic        ts_valid;
  logic        ts_ready;
  logic [63:0] ts_time;
  logic [31:0] ts_delta;
  logic [15:0] ts_index;
  logic        partial_err;
  logic        order_err;

  int vecs = 0;
  int errs = 0;

  logic [31:0] fifo_mem [64];
  int wr_ptr = 0;
  int rd_ptr = 0;

  always #5 clk = ~clk;

  shim_trigger_log_reader #(.PAIR_TIMEOUT(16)) dut (
    .clk(clk), .resetn(resetn), .data_word_rd_en(data_word_rd_en),
    .data_word(data_word), .data_buf_empty(data_buf_empty), .clear(clear),
    .ts_valid(ts_valid), .ts_ready(ts_ready), .ts_time(ts_time),
    .ts_delta(ts_delta), .ts_index(ts_index), .partial_err(partial_err),
    .order_err(order_err)
  );

  assign data_buf_empty = (wr_ptr == rd_ptr);

  always @(posedge clk) begin
    if (data_word_rd_en) begin
      data_word <= fifo_mem[rd_ptr % 64];
      rd_ptr    <= rd_ptr + 1;
    end
  end

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 64] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_valid(input int max, output int cyc, output bit ok);
    ok  = 1'b0;
    cyc = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ts_valid) begin
        ok  = 1'b1;
        cyc = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; clear = 1'b0; ts_ready = 1'b0; data_word = '0;
    repeat (3) @(negedge clk);
    vecs++;
    if (ts_valid !== 1'b0 || data_word_rd_en !== 1'b0) begin
      errs++; $display("FAIL reset_ctrl valid=%b rd_en=%b want 0 0", ts_valid, data_word_rd_en);
    end
    vecs++;
    if (ts_time !== 64'd0 || ts_delta !== 32'd0 || ts_index !== 16'd0) begin
      errs++; $display("FAIL reset_data time=%h delta=%h idx=%h want 0", ts_time, ts_delta, ts_index);
    end
    vecs++;
    if (partial_err !== 1'b0 || order_err !== 1'b0) begin
      errs++; $display("FAIL reset_err partial=%b order=%b want 0 0", partial_err, order_err);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_first_record();
    int first_rd = -1;
    int vcyc = -1;
    @(posedge clk); #1;
    push(32'h0000_0010); push(32'h0000_0000);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (data_word_rd_en && first_rd < 0) first_rd = i;
      if (ts_valid) begin vcyc = i; break; end
    end
    vecs++;
    if (vcyc < 0 || first_rd < 0 || (vcyc - first_rd) != 3) begin
      errs++; $display("FAIL first_latency got=%0d want 3", vcyc - first_rd);
    end
    vecs++;
    if (ts_time !== 64'h10 || ts_delta !== 32'd0 || ts_index !== 16'd0) begin
      errs++; $display("FAIL first_rec time=%h delta=%h idx=%h want 10 0 0", ts_time, ts_delta, ts_index);
    end
    ts_ready = 1'b1;
    @(posedge clk); #1;
    ts_ready = 1'b0;
    vecs++;
    if (ts_index !== 16'd1 || ts_valid !== 1'b0) begin
      errs++; $display("FAIL first_handshake idx=%h valid=%b want 1 0", ts_index, ts_valid);
    end
  endtask

  task automatic test_carry();
    int c; bit ok;
    ts_ready = 1'b1;
    push(32'hFFFF_FFF0); push(32'h0000_0000);
    push(32'h0000_0005); push(32'h0000_0001);
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h0000_0000_FFFF_FFF0 || ts_delta !== 32'hFFFF_FFE0 || ts_index !== 16'd1) begin
      errs++; $display("FAIL carry_rec1 ok=%b time=%h delta=%h idx=%h want FFFFFFF0 FFFFFFE0 1", ok, ts_time, ts_delta, ts_index);
    end
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || c != 3) begin
      errs++; $display("FAIL throughput ok=%b gap=%0d want 4 cycles", ok, c + 1);
    end
    vecs++;
    if (ts_time !== 64'h1_0000_0005 || ts_delta !== 32'h15 || ts_index !== 16'd2 || order_err !== 1'b0) begin
      errs++; $display("FAIL carry_rec2 time=%h delta=%h idx=%h ord=%b want 100000005 15 2 0", ts_time, ts_delta, ts_index, order_err);
    end
    @(posedge clk); #1;
    ts_ready = 1'b0;
  endtask

  task automatic test_partial();
    bit saw_valid = 1'b0;
    ts_ready = 1'b1;
    push(32'h0000_1234);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (ts_valid) saw_valid = 1'b1;
      if (i == 12) begin
        vecs++;
        if (partial_err !== 1'b0) begin
          errs++; $display("FAIL partial_early got=%b want 0", partial_err);
        end
      end
    end
    vecs++;
    if (partial_err !== 1'b1 || saw_valid) begin
      errs++; $display("FAIL partial_timeout err=%b saw_valid=%b want 1 0", partial_err, saw_valid);
    end
    ts_ready = 1'b0;
  endtask

  task automatic test_order();
    int c; bit ok;
    vecs++;
    if (partial_err !== 1'b1) begin
      errs++; $display("FAIL partial_sticky got=%b want 1", partial_err);
    end
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    vecs++;
    if (partial_err !== 1'b0 || order_err !== 1'b0 || ts_index !== 16'd0) begin
      errs++; $display("FAIL clear_idle partial=%b order=%b idx=%h want 0 0 0", partial_err, order_err, ts_index);
    end
    ts_ready = 1'b1;
    push(32'h0000_0100); push(32'h0);
    push(32'h0000_0080); push(32'h0);
    push(32'h0000_0080); push(32'h2);
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h100 || ts_delta !== 32'd0 || ts_index !== 16'd0 || order_err !== 1'b0) begin
      errs++; $display("FAIL order_rec1 time=%h delta=%h idx=%h ord=%b want 100 0 0 0", ts_time, ts_delta, ts_index, order_err);
    end
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h80 || ts_delta !== 32'd0 || ts_index !== 16'd1 || order_err !== 1'b1) begin
      errs++; $display("FAIL order_rec2 time=%h delta=%h idx=%h ord=%b want 80 0 1 1", ts_time, ts_delta, ts_index, order_err);
    end
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h2_0000_0080 || ts_delta !== 32'hFFFF_FFFF || ts_index !== 16'd2) begin
      errs++; $display("FAIL delta_sat time=%h delta=%h idx=%h want 200000080 FFFFFFFF 2", ts_time, ts_delta, ts_index);
    end
    @(posedge clk); #1;
    ts_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    int c; bit ok;
    push(32'h0); push(32'h3);
    push(32'h10); push(32'h3);
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h3_0000_0000 || ts_index !== 16'd3) begin
      errs++; $display("FAIL bp_rec ok=%b time=%h idx=%h want 300000000 3", ok, ts_time, ts_index);
    end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vecs++;
      if (ts_valid !== 1'b1 || ts_time !== 64'h3_0000_0000 || data_word_rd_en !== 1'b0) begin
        errs++; $display("FAIL bp_stall cyc=%0d valid=%b time=%h rd_en=%b want 1 300000000 0", i, ts_valid, ts_time, data_word_rd_en);
      end
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    vecs++;
    if (ts_valid !== 1'b0 || ts_index !== 16'd0 || order_err !== 1'b0) begin
      errs++; $display("FAIL clear_out valid=%b idx=%h ord=%b want 0 0 0", ts_valid, ts_index, order_err);
    end
    ts_ready = 1'b1;
    wait_valid(20, c, ok);
    vecs++;
    if (!ok || ts_time !== 64'h3_0000_0010 || ts_delta !== 32'd0 || ts_index !== 16'd0) begin
      errs++; $display("FAIL post_clear time=%h delta=%h idx=%h want 300000010 0 0", ts_time, ts_delta, ts_index);
    end
    @(posedge clk); #1;
    ts_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_first_record();
    test_carry();
    test_partial();
    test_order();
    test_backpressure();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/shim_trigger_log_reader.md
SHIM_TRIGGER_LOG_READER -- requirements
Module: shim_trigger_log_reader

Interface
REQ-001 The block SHALL have one clock and a reset that is asynchronous and active-low (clk, resetn); no other clock or reset SHALL exist.
REQ-002 Parameter PAIR_TIMEOUT, default 16, SHALL set the maximum number of cycles to wait for a high word after its low word.
REQ-003 Port clk, input, 1, SHALL be the system clock; all logic is rising-edge.
REQ-004 Port resetn, input, 1, SHALL be the asynchronous active-low reset.
REQ-005 Port data_word_rd_en, output, 1, SHALL be the trigger-log FIFO read strobe (combinational).
REQ-006 Port data_word, input, 32, SHALL be the FIFO read data, valid the cycle after data_word_rd_en (standard, non-FWFT).
REQ-007 Port data_buf_empty, input, 1, SHALL be the FIFO empty flag.
REQ-008 Port clear, input, 1, SHALL be the synchronous soft clear.
REQ-009 Ports ts_valid output 1, ts_ready input 1 SHALL be the output valid/ready handshake.
REQ-010 Port ts_time, output, 64, SHALL be the timestamp {high word, low word}.
REQ-011 Port ts_delta, output, 32, SHALL be ts_time minus previous ts_time, saturated.
REQ-012 Port ts_index, output, 16, SHALL be the record sequence number (wraps).
REQ-013 Ports partial_err, order_err, output, 1 each, SHALL be sticky error flags.

Function
REQ-014 FSM states SHALL be S_IDLE, S_RD_LO, S_WAIT_HI, S_RD_HI, S_OUT.
REQ-015 data_word_rd_en SHALL be 1 only when (S_IDLE, S_RD_LO or S_WAIT_HI) and !data_buf_empty and !clear.
REQ-016 S_IDLE: rd_en -> S_RD_LO.
REQ-017 S_RD_LO: latch data_word as low word; if rd_en -> S_RD_HI, else -> S_WAIT_HI with wait counter = 0.
REQ-018 S_WAIT_HI: counter increments each cycle; rd_en -> S_RD_HI; counter reaching PAIR_TIMEOUT with FIFO empty -> set partial_err, drop low word, -> S_IDLE.
REQ-019 S_RD_HI: latch data_word as high word; compute ts_time, ts_delta, order check; -> S_OUT.
REQ-020 S_OUT: ts_valid = 1 with outputs stable until ts_valid && ts_ready; on handshake ts_index increments (wrap 0xFFFF -> 0), -> S_IDLE.
REQ-021 Latency SHALL be 3 cycles from first rd_en to ts_valid when both words are present; ready held high -> one record per 4 cycles.
REQ-022 ts_delta SHALL be 0 for the first record after reset/clear; otherwise new - prev, saturated to 0xFFFFFFFF if >= 2^32.
REQ-023 If not first record and new ts_time <= previous, order_err SHALL set and ts_delta SHALL be 0; the record is still output.
REQ-024 Previous-timestamp register SHALL update on each S_RD_HI.
REQ-025 clear SHALL, in any state, return FSM to S_IDLE next cycle, drop any partial/pending record (ts_valid low next cycle), zero ts_index and error flags, and re-arm first-record handling; clear has priority over all other events.
REQ-026 No FIFO read SHALL be issued in S_RD_HI or S_OUT (backpressure stalls reads).

Reset
REQ-027 On resetn low: state S_IDLE, ts_valid 0, ts_time 0, ts_delta 0, ts_index 0, partial_err 0, order_err 0, wait counter 0, first-record flag set; data_word_rd_en 0 while in reset.
REQ-028 Reset mid-record SHALL discard the record; no recovery of read words.

Structure
REQ-029 State encoding and the 32-bit delta saturation constant SHALL live in the shared shim package alongside the trigger command/state encodings.
REQ-030 Block SHALL be a single module; no sub-module.

Verification
REQ-031 FIFO holds 0x00000010, 0x00000000 -> ts_time 0x10, ts_delta 0, ts_index 0, ts_valid 3 cycles after first rd_en.
REQ-032 Second pair 0xFFFFFFF0/0x0, then 0x00000005/0x1 -> ts_time 0x1_00000005, ts_delta 0x15, no carry error.
REQ-033 Low word only, FIFO empty 16 cycles -> partial_err=1, FSM S_IDLE, no ts_valid.
REQ-034 Record 0x100 then 0x80 -> order_err=1, second ts_delta 0; delta 0x2_00000000 gap -> ts_delta 0xFFFFFFFF.
REQ-035 ts_ready low 10 cycles with FIFO full -> ts_valid/outputs stable, rd_en 0 throughout; clear asserted during S_OUT -> ts_valid 0 next cycle, ts_index 0.
